// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin arbiter sharing one UART byte transmitter between N_REQ
//           ready/valid byte sources, with burst locking and idle-hold timeout.
// Latency : issue one clock after a requester is seen in IDLE; frame end
//           detected on the FRAME_TICKS-th tick after the tx_go cycle.
// Backpressure: req_ready is a one-cycle accept pulse. Valid is sampled only in
//           IDLE, so sources simply hold valid until accepted.
//
// Ports:
//   clock, rst_n      rising-edge clock, synchronous active-low reset
//   tick              baud enable pulse shared with the transmitter
//   req_valid/_data/_last  per-requester byte offer (byte i at [8*i+7:8*i])
//   req_ready         one-hot accept pulse
//   tx_go, tx_data    start pulse and byte to the transmitter (byte held after go)
//   grant_id          current or last owner
//   locked            burst in progress, owner keeps the grant
//   lock_abort        pulse when the hold timeout releases an unfinished burst
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int IDX_W       = 2,
    parameter int FRAME_TICKS = 10,
    parameter int HOLD_TICKS  = 20
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_go,
    output logic [7:0]           tx_data,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 locked,
    output logic                 lock_abort
);

    localparam int FRAME_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int HOLD_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [FRAME_W-1:0] frame_cnt;
    logic [HOLD_W-1:0]  hold_cnt;

    // Byte lanes split out so they can be indexed by the grant index.
    logic [7:0] req_byte [N_REQ];
    for (genvar g = 0; g < N_REQ; g++) begin : g_byte
        assign req_byte[g] = req_data[8*g +: 8];
    end

    // Round-robin search: walk offsets from high to low so the requester
    // closest to rr_ptr (lowest offset) is the one left standing.
    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] arb_cand;
    int               arb_sum;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        arb_sum   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            arb_sum = int'(rr_ptr) + k;
            if (arb_sum >= N_REQ) begin
                arb_sum = arb_sum - N_REQ;
            end
            arb_cand = IDX_W'(arb_sum);
            if (req_valid[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    // A locked owner bypasses arbitration entirely.
    logic             issue_en;
    logic [IDX_W-1:0] issue_idx;
    logic [IDX_W-1:0] rr_next;

    always_comb begin
        issue_en  = 1'b0;
        issue_idx = '0;
        if (state == S_IDLE) begin
            if (locked) begin
                issue_en  = req_valid[grant_id];
                issue_idx = grant_id;
            end else begin
                issue_en  = arb_found;
                issue_idx = arb_idx;
            end
        end
        rr_next = (issue_idx == IDX_W'(N_REQ - 1)) ? '0 : issue_idx + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            frame_cnt  <= '0;
            hold_cnt   <= '0;
            req_ready  <= '0;
            tx_go      <= 1'b0;
            tx_data    <= '0;
            grant_id   <= '0;
            locked     <= 1'b0;
            lock_abort <= 1'b0;
        end else begin
            tx_go      <= 1'b0;
            req_ready  <= '0;
            lock_abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (issue_en) begin
                        grant_id  <= issue_idx;
                        tx_data   <= req_byte[issue_idx];
                        tx_go     <= 1'b1;
                        req_ready <= N_REQ'(1) << issue_idx;
                        locked    <= ~req_last[issue_idx];
                        if (req_last[issue_idx]) begin
                            rr_ptr <= rr_next;
                        end
                        frame_cnt <= '0;
                        state     <= S_WAIT;
                    end else if (locked && tick) begin
                        // Owner idle between burst bytes; give up after HOLD_TICKS.
                        if (hold_cnt == HOLD_W'(HOLD_TICKS - 1)) begin
                            hold_cnt   <= '0;
                            locked     <= 1'b0;
                            lock_abort <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    // The tick alongside tx_go precedes the transmitter's frame.
                    if (tick && !tx_go) begin
                        if (frame_cnt == FRAME_W'(FRAME_TICKS - 1)) begin
                            frame_cnt <= '0;
                            hold_cnt  <= '0;
                            state     <= S_IDLE;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
